// File: rtl/yarp_pkg.sv
// rtl/yarp_pkg.sv - shared types for the yarp writeback arbiter
package yarp_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_EX, GNT_LD} wb_gnt_e;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    rd_onehot = 32'd1 << rd;
  endfunction

endpackage

// File: rtl/yarp_wb_slot.sv
// rtl/yarp_wb_slot.sv - 1-entry writeback holding slot; x0 requests are consumed but dropped
module yarp_wb_slot
  import yarp_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    valid_i,
  output logic    ready_o,
  input  wb_req_t req_i,
  input  logic    grant_i,
  output logic    full_o,
  output wb_req_t req_o,
  output logic    fill_o
);

  logic    full_q, full_d;
  wb_req_t req_q, req_d;

  // A granted slot drains this edge, so it may be refilled in the same cycle.
  assign ready_o = !full_q || grant_i;
  assign fill_o  = valid_i && ready_o && (req_i.rd != 5'd0);

  always_comb begin
    full_d = full_q;
    req_d  = req_q;
    if (fill_o) begin
      full_d = 1'b1;
      req_d  = req_i;
    end else if (grant_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

  assign full_o = full_q;
  assign req_o  = req_q;

endmodule

// File: rtl/yarp_wb_arbiter.sv
// rtl/yarp_wb_arbiter.sv - arbitrates ex/ld writeback onto the regfile write port
// Optional conflict statistics counter enabled by YARP_WB_ARB_STATS_EN.
module yarp_wb_arbiter
  import yarp_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [4:0]      ex_rd_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  input  logic [4:0]      ld_rd_i,
  input  logic [XLEN-1:0] ld_data_i,
  output logic [4:0]      rd_addr_o,
  output logic            wr_en_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic [31:0]     pending_mask_o,
  output logic [15:0]     conflict_cnt_o
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  wb_req_t ex_req, ld_req;
  logic    ex_full, ld_full, ex_fill, ld_fill;
  wb_gnt_e gnt;
  logic    grant_ex, grant_ld;

  logic [3:0]      age_q, age_d;
  logic            ld_older_q, ld_older_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;

  assign grant_ex = (gnt == GNT_EX);
  assign grant_ld = (gnt == GNT_LD);

  yarp_wb_slot u_ex_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i (ex_valid_i),
    .ready_o (ex_ready_o),
    .req_i   ('{rd: ex_rd_i, data: ex_data_i}),
    .grant_i (grant_ex),
    .full_o  (ex_full),
    .req_o   (ex_req),
    .fill_o  (ex_fill)
  );

  yarp_wb_slot u_ld_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i (ld_valid_i),
    .ready_o (ld_ready_o),
    .req_i   ('{rd: ld_rd_i, data: ld_data_i}),
    .grant_i (grant_ld),
    .full_o  (ld_full),
    .req_o   (ld_req),
    .fill_o  (ld_fill)
  );

  // Same-rd collisions must retire in arrival order, ahead of aging and priority.
  always_comb begin
    gnt = GNT_NONE;
    if (ex_full && ld_full) begin
      if (ex_req.rd == ld_req.rd) gnt = ld_older_q ? GNT_LD : GNT_EX;
      else if (age_q == MAX_WAIT_C) gnt = GNT_EX;
      else gnt = GNT_LD;
    end else if (ex_full) begin
      gnt = GNT_EX;
    end else if (ld_full) begin
      gnt = GNT_LD;
    end
  end

  always_comb begin
    ld_older_d = ld_older_q;
    if (ex_fill) ld_older_d = ld_fill || (ld_full && !grant_ld);
    else if (ld_fill) ld_older_d = 1'b0;

    age_d = 4'd0;
    if (ex_full && grant_ld) age_d = (age_q == MAX_WAIT_C) ? age_q : age_q + 4'd1;

    wr_en_d = (gnt != GNT_NONE);
    rd_d    = rd_q;
    data_d  = data_q;
    if (grant_ex) begin
      rd_d   = ex_req.rd;
      data_d = ex_req.data;
    end else if (grant_ld) begin
      rd_d   = ld_req.rd;
      data_d = ld_req.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      age_q      <= 4'd0;
      ld_older_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_q       <= 5'd0;
      data_q     <= '0;
    end else begin
      age_q      <= age_d;
      ld_older_q <= ld_older_d;
      wr_en_q    <= wr_en_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign rd_addr_o = rd_q;
  assign wr_data_o = data_q;

  always_comb begin
    pending_mask_o = 32'd0;
    if (ex_full) pending_mask_o = pending_mask_o | rd_onehot(ex_req.rd);
    if (ld_full) pending_mask_o = pending_mask_o | rd_onehot(ld_req.rd);
  end

`ifdef YARP_WB_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (ex_full && ld_full && (conflict_q != 16'hFFFF)) conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) conflict_q <= 16'd0;
    else conflict_q <= conflict_d;
  end

  assign conflict_cnt_o = conflict_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_yarp_wb_arbiter.sv
// tb/tb_yarp_wb_arbiter.sv - scoreboard bench for yarp_wb_arbiter
module tb_yarp_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid_i = 1'b0, ld_valid_i = 1'b0;
  logic        ex_ready_o, ld_ready_o;
  logic [4:0]  ex_rd_i = '0, ld_rd_i = '0;
  logic [31:0] ex_data_i = '0, ld_data_i = '0;
  logic [4:0]  rd_addr_o;
  logic        wr_en_o;
  logic [31:0] wr_data_o;
  logic [31:0] pending_mask_o;
  logic [15:0] conflict_cnt_o;

`ifdef YARP_WB_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  yarp_wb_arbiter #(.MAX_WAIT(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ex_valid_i     (ex_valid_i),
    .ex_ready_o     (ex_ready_o),
    .ex_rd_i        (ex_rd_i),
    .ex_data_i      (ex_data_i),
    .ld_valid_i     (ld_valid_i),
    .ld_ready_o     (ld_ready_o),
    .ld_rd_i        (ld_rd_i),
    .ld_data_i      (ld_data_i),
    .rd_addr_o      (rd_addr_o),
    .wr_en_o        (wr_en_o),
    .wr_data_o      (wr_data_o),
    .pending_mask_o (pending_mask_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      logic [36:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rd_addr_o, wr_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({rd_addr_o, wr_data_o} !== e) begin
          n_err++;
          $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   rd_addr_o, wr_data_o, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int rd, input int data);
    exp_q.push_back({5'(rd), 32'(data)});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    int writes;
    reset_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({wr_en_o, rd_addr_o, wr_data_o, conflict_cnt_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got en=%b rd=%0d data=%h cnt=%0d, required all 0",
               wr_en_o, rd_addr_o, wr_data_o, conflict_cnt_o);
    end
    reset_n = 1'b1;
    tick();
    ex_valid_i = 1'b1; ex_rd_i = 5'd1; ex_data_i = 32'h11;
    ld_valid_i = 1'b1; ld_rd_i = 5'd2; ld_data_i = 32'h22;
    tick();
    ex_valid_i = 1'b0; ld_valid_i = 1'b0;
    n_cmp++;
    if (pending_mask_o !== 32'h6) begin
      n_err++;
      $display("FAIL reset_prefill_mask: got %h, required %h", pending_mask_o, 32'h6);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_cmp++;
    if ({wr_en_o, pending_mask_o, ex_ready_o, ld_ready_o} !== {1'b0, 32'h0, 2'b11}) begin
      n_err++;
      $display("FAIL reset_midop: got en=%b mask=%h rdy=%b%b, required en=0 mask=0 rdy=11",
               wr_en_o, pending_mask_o, ex_ready_o, ld_ready_o);
    end
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wr_en_o) writes++;
    end
    n_cmp++;
    if (writes != 0) begin
      n_err++;
      $display("FAIL reset_no_late_write: got %0d writes, required 0", writes);
    end
  endtask

  task automatic test_single();
    ex_valid_i = 1'b1; ex_rd_i = 5'd5; ex_data_i = 32'hDEAD;
    n_cmp++;
    if (ex_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_ready: got %b, required 1", ex_ready_o);
    end
    push(5, 32'hDEAD);
    tick();
    ex_valid_i = 1'b0;
    n_cmp++;
    if ({wr_en_o, pending_mask_o} !== {1'b0, 32'h20}) begin
      n_err++;
      $display("FAIL single_t1: got en=%b mask=%h, required en=0 mask=00000020", wr_en_o, pending_mask_o);
    end
    tick();
    n_cmp++;
    if ({wr_en_o, rd_addr_o, wr_data_o, pending_mask_o} !== {1'b1, 5'd5, 32'hDEAD, 32'h0}) begin
      n_err++;
      $display("FAIL single_t2: got en=%b rd=%0d data=%h mask=%h, required en=1 rd=5 data=dead mask=0",
               wr_en_o, rd_addr_o, wr_data_o, pending_mask_o);
    end
    tick();
    n_cmp++;
    if ({wr_en_o, rd_addr_o, wr_data_o} !== {1'b0, 5'd5, 32'hDEAD}) begin
      n_err++;
      $display("FAIL single_hold: got en=%b rd=%0d data=%h, required en=0 rd=5 data=dead",
               wr_en_o, rd_addr_o, wr_data_o);
    end
    drain("single");
  endtask

  task automatic test_priority();
    logic [15:0] c0;
    c0 = conflict_cnt_o;
    ex_valid_i = 1'b1; ex_rd_i = 5'd3; ex_data_i = 32'h33;
    ld_valid_i = 1'b1; ld_rd_i = 5'd4; ld_data_i = 32'h44;
    push(4, 32'h44);
    push(3, 32'h33);
    tick();
    ex_valid_i = 1'b0; ld_valid_i = 1'b0;
    n_cmp++;
    if (pending_mask_o !== 32'h18) begin
      n_err++;
      $display("FAIL priority_mask: got %h, required %h", pending_mask_o, 32'h18);
    end
    drain("priority");
    n_cmp++;
    if (conflict_cnt_o - c0 !== 16'(STATS)) begin
      n_err++;
      $display("FAIL priority_conflicts: got %0d, required %0d", conflict_cnt_o - c0, STATS);
    end
  endtask

  task automatic test_aging();
    int idx;
    logic hs;
    logic [15:0] c0;
    c0 = conflict_cnt_o;
    idx = 8;
    ex_valid_i = 1'b1; ex_rd_i = 5'd7; ex_data_i = 32'd77;
    ld_valid_i = 1'b1; ld_rd_i = 5'd8; ld_data_i = 32'd108;
    for (int r = 8; r <= 11; r++) push(r, 100 + r);
    push(7, 77);
    push(12, 112);
    for (int c = 0; c < 12; c++) begin
      hs = ld_valid_i && ld_ready_o;
      if (c == 2) begin
        n_cmp++;
        if (ex_ready_o !== 1'b0) begin
          n_err++;
          $display("FAIL aging_ex_held: got ready=%b, required 0", ex_ready_o);
        end
      end
      tick();
      ex_valid_i = 1'b0;
      if (hs) begin
        idx++;
        if (idx > 12) ld_valid_i = 1'b0;
        else begin
          ld_rd_i = 5'(idx);
          ld_data_i = 32'(100 + idx);
        end
      end
    end
    drain("aging");
    n_cmp++;
    if (conflict_cnt_o - c0 !== 16'(5 * STATS)) begin
      n_err++;
      $display("FAIL aging_conflicts: got %0d, required %0d", conflict_cnt_o - c0, 5 * STATS);
    end
  endtask

  task automatic test_waw();
    ld_valid_i = 1'b1; ld_rd_i = 5'd9; ld_data_i = 32'd1;
    push(9, 1);
    push(9, 2);
    tick();
    ld_valid_i = 1'b0;
    ex_valid_i = 1'b1; ex_rd_i = 5'd9; ex_data_i = 32'd2;
    n_cmp++;
    if (pending_mask_o !== 32'h200) begin
      n_err++;
      $display("FAIL waw_ld_pending: got %h, required %h", pending_mask_o, 32'h200);
    end
    tick();
    ex_valid_i = 1'b0;
    drain("waw_basic");
    // ex x9 older than a later ld x9 must win despite ld priority
    ex_valid_i = 1'b1; ex_rd_i = 5'd9; ex_data_i = 32'hA;
    ld_valid_i = 1'b1; ld_rd_i = 5'd6; ld_data_i = 32'd60;
    push(6, 60);
    push(9, 32'hA);
    push(9, 32'hB);
    tick();
    ex_valid_i = 1'b0;
    ld_rd_i = 5'd9; ld_data_i = 32'hB;
    tick();
    ld_valid_i = 1'b0;
    n_cmp++;
    if (pending_mask_o !== 32'h200) begin
      n_err++;
      $display("FAIL waw_both_pending: got %h, required %h", pending_mask_o, 32'h200);
    end
    drain("waw_ex_older");
    ex_valid_i = 1'b1; ex_rd_i = 5'd10; ex_data_i = 32'd1;
    ld_valid_i = 1'b1; ld_rd_i = 5'd10; ld_data_i = 32'd2;
    push(10, 2);
    push(10, 1);
    tick();
    ex_valid_i = 1'b0; ld_valid_i = 1'b0;
    drain("waw_same_cycle");
  endtask

  task automatic test_x0_stats();
    int writes;
    logic [15:0] c0;
    ex_valid_i = 1'b1; ex_rd_i = 5'd0; ex_data_i = 32'hFFFF;
    ld_valid_i = 1'b1; ld_rd_i = 5'd0; ld_data_i = 32'hEEEE;
    n_cmp++;
    if ({ex_ready_o, ld_ready_o} !== 2'b11) begin
      n_err++;
      $display("FAIL x0_ready: got %b%b, required 11", ex_ready_o, ld_ready_o);
    end
    tick();
    ex_valid_i = 1'b0; ld_valid_i = 1'b0;
    n_cmp++;
    if (pending_mask_o !== 32'h0) begin
      n_err++;
      $display("FAIL x0_mask: got %h, required 0", pending_mask_o);
    end
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wr_en_o) writes++;
    end
    n_cmp++;
    if (writes != 0) begin
      n_err++;
      $display("FAIL x0_no_write: got %0d writes, required 0", writes);
    end
    c0 = conflict_cnt_o;
    ex_valid_i = 1'b1; ex_rd_i = 5'd1; ex_data_i = 32'd1;
    ld_valid_i = 1'b1; ld_rd_i = 5'd2; ld_data_i = 32'd2;
    push(2, 2);
    push(3, 3);
    push(4, 4);
    push(1, 1);
    tick();
    ex_valid_i = 1'b0;
    ld_rd_i = 5'd3; ld_data_i = 32'd3;
    tick();
    ld_rd_i = 5'd4; ld_data_i = 32'd4;
    tick();
    ld_valid_i = 1'b0;
    drain("stats");
    n_cmp++;
    if (conflict_cnt_o - c0 !== 16'(3 * STATS)) begin
      n_err++;
      $display("FAIL stats_conflicts: got %0d, required %0d", conflict_cnt_o - c0, 3 * STATS);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      ex_valid_i = 1'b1; ex_rd_i = 5'(16 + k); ex_data_i = 32'(32'h1000 + k);
      push(16 + k, 32'h1000 + k);
      n_cmp++;
      if (ex_ready_o !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready_%0d: got %b, required 1", k, ex_ready_o);
      end
      if (k >= 2) begin
        n_cmp++;
        if (wr_en_o !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_throughput_%0d: got wr_en=%b, required 1", k, wr_en_o);
        end
      end
      tick();
    end
    ex_valid_i = 1'b0;
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_aging();
    test_waw();
    test_x0_stats();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
